// File: rtl/lifo_rd_ctrl_if.sv
// Signal bundle between lifo_rd_ctrl, its upstream LIFO read port and the downstream stream sink.
// word_cnt_o exists only when LIFO_RD_CTRL_WORD_CNT_EN is defined.
interface lifo_rd_ctrl_if #(
  parameter int DWIDTH = 8
);
  logic              empty_i;
  logic              rdreq_o;
  logic [DWIDTH-1:0] q_i;
  logic [DWIDTH-1:0] data_o;
  logic              valid_o;
  logic              ready_i;
  logic              flush_i;
  logic              flush_done_o;

`ifdef LIFO_RD_CTRL_WORD_CNT_EN
  logic [31:0]       word_cnt_o;

  modport slave (
    input  empty_i, q_i, ready_i, flush_i,
    output rdreq_o, data_o, valid_o, flush_done_o, word_cnt_o
  );

  modport master (
    output empty_i, q_i, ready_i, flush_i,
    input  rdreq_o, data_o, valid_o, flush_done_o, word_cnt_o
  );
`else
  modport slave (
    input  empty_i, q_i, ready_i, flush_i,
    output rdreq_o, data_o, valid_o, flush_done_o
  );

  modport master (
    output empty_i, q_i, ready_i, flush_i,
    input  rdreq_o, data_o, valid_o, flush_done_o
  );
`endif

endinterface

// File: rtl/lifo_rd_ctrl.sv
// Turns a one-cycle-latency LIFO read port into a valid/ready stream through a 2-entry buffer,
// with a flush that drains the LIFO. Define LIFO_RD_CTRL_WORD_CNT_EN to add the word_cnt_o counter.
module lifo_rd_ctrl #(
  parameter int DWIDTH = 8
) (
  input  logic          clk_i,
  input  logic          arst_n_i,
  lifo_rd_ctrl_if.slave lif
);

  typedef enum logic [1:0] {
    STREAM = 2'd0,
    FLUSH  = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_run;
  logic              r_inflight;
  logic [1:0]        r_count;
  logic [DWIDTH-1:0] r_buf [2];

  logic              w_valid;
  logic              w_pop;
  logic              w_capture;
  logic              w_flush_acc;
  logic              w_rdreq;
  logic              w_flush_done;
  logic [1:0]        w_occ;
  logic [1:0]        w_occ_after_pop;

  assign w_valid         = (r_count != 2'd0);
  assign w_pop           = (r_state == STREAM) && w_valid && lif.ready_i;
  // Data returning outside STREAM belongs to a flushed read and is dropped.
  assign w_capture       = r_inflight && (r_state == STREAM);
  assign w_flush_acc     = (r_state == STREAM) && lif.flush_i;
  assign w_occ           = r_count + {1'b0, r_inflight};
  assign w_occ_after_pop = w_occ - {1'b0, w_pop};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_nxt  = r_state;
    w_rdreq      = 1'b0;
    w_flush_done = 1'b0;
    case (r_state)
      STREAM: begin
        // r_run keeps the read request low until the first edge after reset release.
        w_rdreq = r_run && !lif.empty_i && (w_occ_after_pop < 2'd2);
        if (lif.flush_i) begin
          w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        w_rdreq = !lif.empty_i;
        if (lif.empty_i && !r_inflight) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_flush_done = 1'b1;
        w_state_nxt  = STREAM;
      end
      default: begin
        w_state_nxt = STREAM;
      end
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state    <= STREAM;
      r_run      <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_run      <= 1'b1;
      r_inflight <= w_rdreq;
    end
  end

  // Buffer is kept oldest-first: r_buf[0] is the head presented on data_o.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      // NOTE: the two buffer words are ordinary flops and are reset, so data_o reads 0 out of reset.
      r_count  <= 2'd0;
      r_buf[0] <= '0;
      r_buf[1] <= '0;
    end else if (w_flush_acc) begin
      r_count <= 2'd0;
    end else begin
      case ({w_pop, w_capture})
        2'b11: begin
          if (r_count == 2'd2) begin
            r_buf[0] <= r_buf[1];
            r_buf[1] <= lif.q_i;
          end else begin
            r_buf[0] <= lif.q_i;
          end
        end
        2'b10: begin
          r_buf[0] <= r_buf[1];
          r_count  <= r_count - 2'd1;
        end
        2'b01: begin
          r_buf[r_count[0]] <= lif.q_i;
          r_count           <= r_count + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef LIFO_RD_CTRL_WORD_CNT_EN
  logic [31:0] r_word_cnt;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_word_cnt <= 32'd0;
    end else if (w_flush_acc) begin
      r_word_cnt <= 32'd0;
    end else if (w_pop) begin
      r_word_cnt <= r_word_cnt + 32'd1;
    end
  end

  assign lif.word_cnt_o = r_word_cnt;
`endif

  assign lif.rdreq_o      = w_rdreq;
  assign lif.valid_o      = w_valid;
  assign lif.data_o       = r_buf[0];
  assign lif.flush_done_o = w_flush_done;

endmodule

// File: tb/tb_lifo_rd_ctrl.sv
// Self-checking bench for lifo_rd_ctrl: behavioural LIFO model, output scoreboard,
// cycle vector table, and hand-written flush / reset / word-counter sequences.
module tb_lifo_rd_ctrl;

  localparam int DWIDTH = 8;

  typedef struct {
    logic       ready;
    logic       exp_rdreq;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  logic clk;
  logic arst_n;

  lifo_rd_ctrl_if #(.DWIDTH(DWIDTH)) lif ();

  lifo_rd_ctrl #(.DWIDTH(DWIDTH)) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .lif      (lif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         n_tests = 0;
  int         n_fail  = 0;
  int         out_cnt = 0;
  logic       sb_en   = 1'b1;
  logic [7:0] lifo  [$];
  logic [7:0] exp_q [$];
  logic       s_rdreq;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_done;
  vec_t       vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    lifo.push_back(w);
    lif.empty_i = 1'b0;
  endtask

  // One clock cycle: sample outputs at the falling edge, then answer the read at the rising edge.
  task automatic tick();
    logic [7:0] w;
    @(negedge clk);
    s_rdreq = lif.rdreq_o;
    s_valid = lif.valid_o;
    s_data  = lif.data_o;
    s_done  = lif.flush_done_o;
    check("rdreq_vs_empty", 32'(s_rdreq & lif.empty_i), 32'd0);
    if (s_valid && lif.ready_i) begin
      out_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got word 0x%0h, expected none (t=%0t)", s_data, $time);
      end else begin
        check("sb_data", 32'(s_data), 32'(exp_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
    if (s_rdreq) begin
      if (lifo.size() == 0) begin
        lif.q_i = '0;
      end else begin
        w = lifo.pop_back();
        lif.q_i = w;
        if (sb_en) exp_q.push_back(w);
      end
    end
    lif.empty_i = (lifo.size() == 0);
  endtask

  task automatic apply_vectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      lif.ready_i = vecs[i].ready;
      tick();
      check($sformatf("vec%0d_rdreq", i), 32'(s_rdreq), 32'(vecs[i].exp_rdreq));
      check($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_data", i), 32'(s_data), 32'(vecs[i].exp_data));
      end
    end
  endtask

  task automatic run_until_out(input int n, input string name);
    int start;
    int cyc;
    start = out_cnt;
    cyc   = 0;
    while ((out_cnt - start) < n && cyc < 200) begin
      tick();
      cyc++;
    end
    check(name, out_cnt - start, n);
  endtask

  initial begin
    int rd_cnt;
    int vh_cnt;
    int dn_cnt;
    int pushed;
    int start;

    // LIFO preloaded 0x11,0x22,0x33 (top 0x33), ready high: start latency, then one word per cycle.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 8'h33};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'h22};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 8'h11};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h00};
    // LIFO preloaded 0x41..0x46, ready low 5 cycles (two reads only), then ready high.
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h46};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h46};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h46};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 8'h46};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 8'h45};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 8'h44};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 8'h43};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 8'h42};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 8'h41};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 8'h00};

    arst_n      = 1'b0;
    lif.ready_i = 1'b0;
    lif.flush_i = 1'b0;
    lif.empty_i = 1'b1;
    lif.q_i     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdreq", 32'(lif.rdreq_o), 32'd0);
    check("rst_valid", 32'(lif.valid_o), 32'd0);
    check("rst_data", 32'(lif.data_o), 32'd0);
    check("rst_done", 32'(lif.flush_done_o), 32'd0);

    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    lif.ready_i = 1'b1;
    #1;
    check("rst_rdreq_nonempty", 32'(lif.rdreq_o), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    check("rdreq_before_first_edge", 32'(lif.rdreq_o), 32'd0);

    apply_vectors(0, 5);
    for (int k = 0; k < 6; k++) push_word(8'(8'h41 + k));
    apply_vectors(6, 17);
    check("vec_sb_empty", exp_q.size(), 0);

    // Random ready over 1000 words with the LIFO refilled on the fly.
    pushed = 0;
    start  = out_cnt;
    for (int cyc = 0; cyc < 20000 && (out_cnt - start) < 1000; cyc++) begin
      lif.ready_i = 1'($urandom_range(0, 1));
      if (pushed < 1000 && $urandom_range(0, 2) != 0) begin
        push_word(8'($urandom_range(0, 255)));
        pushed++;
      end
      tick();
    end
    check("rand_words_out", out_cnt - start, 1000);
    check("rand_sb_left", exp_q.size(), 0);

    // Flush with two words buffered and four left in the LIFO.
    for (int k = 0; k < 6; k++) push_word(8'(8'h61 + k));
    lif.ready_i = 1'b0;
    repeat (5) tick();
    check("fl_pre_valid", 32'(s_valid), 32'd1);
    check("fl_pre_data", 32'(s_data), 32'h66);
    check("fl_pre_lifo", lifo.size(), 4);
    exp_q.delete();
    sb_en       = 1'b0;
    lif.flush_i = 1'b1;
    tick();
    check("fl_accept_valid", 32'(s_valid), 32'd1);
    lif.ready_i = 1'b1;
    rd_cnt = 0;
    vh_cnt = 0;
    dn_cnt = 0;
    for (int j = 0; j < 20 && dn_cnt == 0; j++) begin
      tick();
      rd_cnt += int'(s_rdreq);
      vh_cnt += int'(s_valid);
      dn_cnt += int'(s_done);
    end
    lif.flush_i = 1'b0;
    check("fl_rdreq_pulses", rd_cnt, 4);
    check("fl_valid_cycles", vh_cnt, 0);
    check("fl_done_seen", dn_cnt, 1);
    check("fl_lifo_drained", lifo.size(), 0);
    tick();
    check("fl_done_single", 32'(s_done), 32'd0);
    check("fl_after_valid", 32'(s_valid), 32'd0);
    sb_en = 1'b1;
    push_word(8'h77);
    run_until_out(1, "fl_resume_out");
    check("fl_resume_data", 32'(s_data), 32'h77);

    // Asynchronous reset while a word is buffered and the next read is in flight.
    push_word(8'h81);
    push_word(8'h82);
    push_word(8'h83);
    lif.ready_i = 1'b0;
    tick();
    tick();
    check("mid_valid_before_rst", 32'(lif.valid_o), 32'd1);
    arst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(lif.valid_o), 32'd0);
    check("mid_rst_rdreq", 32'(lif.rdreq_o), 32'd0);
    check("mid_rst_data", 32'(lif.data_o), 32'd0);
    check("mid_rst_done", 32'(lif.flush_done_o), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    #1;
    check("mid_rdreq_after_release", 32'(lif.rdreq_o), 32'd0);
    lif.ready_i = 1'b1;
    run_until_out(1, "mid_resume_out");
    check("mid_resume_data", 32'(s_data), 32'h81);
    repeat (3) tick();
    check("mid_no_extra_word", out_cnt - start - 1002, 0);

`ifdef LIFO_RD_CTRL_WORD_CNT_EN
    arst_n = 1'b0;
    #1;
    check("wc_reset", lif.word_cnt_o, 32'd0);
    exp_q.delete();
    @(negedge clk);
    arst_n = 1'b1;
    for (int k = 0; k < 10; k++) push_word(8'(8'hA0 + k));
    lif.ready_i = 1'b1;
    run_until_out(10, "wc_ten_out");
    check("wc_ten", lif.word_cnt_o, 32'd10);
    force dut.r_word_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_word_cnt;
    check("wc_forced", lif.word_cnt_o, 32'hFFFF_FFFF);
    push_word(8'hB1);
    run_until_out(1, "wc_wrap_out");
    check("wc_wrap", lif.word_cnt_o, 32'd0);
    push_word(8'hB2);
    run_until_out(1, "wc_one_out");
    check("wc_one", lif.word_cnt_o, 32'd1);
    sb_en       = 1'b0;
    lif.flush_i = 1'b1;
    tick();
    lif.flush_i = 1'b0;
    check("wc_flush", lif.word_cnt_o, 32'd0);
    dn_cnt = 0;
    for (int j = 0; j < 20 && dn_cnt == 0; j++) begin
      tick();
      dn_cnt += int'(s_done);
    end
    check("wc_flush_done", dn_cnt, 1);
    sb_en = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
